// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one external 16x16 signed multiplier between N_CLI requesters.
//   A round-robin pointer picks the next client, its operands and parity
//   bits are latched toward the multiplier, and the product (with the
//   multiplier's own parity and parity-error flags) is returned to the
//   winner as a one-cycle cli_done pulse. A bounded wait on m_ack and on
//   m_result_rdy turns a hung multiplier into a flagged, zero-valued
//   completion, so no client can be blocked forever.
//
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   cli_req[N_CLI]        request levels, operands held until cli_done
//   cli_a, cli_b          16-bit signed operands, client i at [16i+15:16i]
//   cli_a_par, cli_b_par  operand parity bits, passed through untouched
//   cli_done[N_CLI]       one-hot completion pulse
//   cli_result            signed product, valid with cli_done
//   cli_result_par        result parity from the multiplier
//   cli_par_err           multiplier parity-error flag
//   cli_timeout           completion caused by the wait bound expiring
//   m_req, m_a, m_b       request, operands to the multiplier
//   m_a_par, m_b_par      operand parity to the multiplier
//   m_ack, m_result_rdy   multiplier handshake
//   m_result, m_result_par, m_par_err  multiplier response
//   busy, grant_id        transaction in flight / client being served
module mult_arbiter #(
  parameter int N_CLI   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CLI-1:0]      cli_req,
  input  logic [N_CLI*16-1:0]   cli_a,
  input  logic [N_CLI*16-1:0]   cli_b,
  input  logic [N_CLI-1:0]      cli_a_par,
  input  logic [N_CLI-1:0]      cli_b_par,
  output logic [N_CLI-1:0]      cli_done,
  output logic [31:0]           cli_result,
  output logic                  cli_result_par,
  output logic                  cli_par_err,
  output logic                  cli_timeout,
  output logic                  m_req,
  output logic [15:0]           m_a,
  output logic [15:0]           m_b,
  output logic                  m_a_par,
  output logic                  m_b_par,
  input  logic                  m_ack,
  input  logic                  m_result_rdy,
  input  logic [31:0]           m_result,
  input  logic                  m_result_par,
  input  logic                  m_par_err,
  output logic                  busy,
  output logic [2:0]            grant_id
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [N_CLI-1:0] ONE = {{(N_CLI-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_r;
  logic [2:0]        rr_ptr_r;
  logic [TW-1:0]     tmo_cnt_r;

  logic [N_CLI-1:0]  hi_req_s;
  logic [2:0]        hi_pick_s;
  logic [2:0]        lo_pick_s;
  logic              found_s;
  logic [2:0]        winner_s;
  logic [15:0]       a_sel_s;
  logic [15:0]       b_sel_s;
  logic              a_par_sel_s;
  logic              b_par_sel_s;
  logic [N_CLI-1:0]  done_vec_s;
  logic [2:0]        nxt_ptr_s;
  logic              tmo_hit_s;
  logic              capture_s;
  logic              expire_s;
  logic              to_wait_s;

  // Round-robin winner: lowest requester at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_req_s  = cli_req & ~((ONE << rr_ptr_r) - ONE);
    hi_pick_s = 3'd0;
    lo_pick_s = 3'd0;
    // Descending scan so the lowest set index is the one left standing.
    for (int j = N_CLI - 1; j >= 0; j--) begin
      hi_pick_s = hi_req_s[j] ? 3'(j) : hi_pick_s;
      lo_pick_s = cli_req[j]  ? 3'(j) : lo_pick_s;
    end
    found_s  = |cli_req;
    winner_s = (|hi_req_s) ? hi_pick_s : lo_pick_s;
  end

  // Operand and parity mux for the selected winner.
  always_comb begin
    a_sel_s     = 16'd0;
    b_sel_s     = 16'd0;
    a_par_sel_s = 1'b0;
    b_par_sel_s = 1'b0;
    for (int k = 0; k < N_CLI; k++) begin
      a_sel_s     = (winner_s == 3'(k)) ? cli_a[16*k +: 16] : a_sel_s;
      b_sel_s     = (winner_s == 3'(k)) ? cli_b[16*k +: 16] : b_sel_s;
      a_par_sel_s = (winner_s == 3'(k)) ? cli_a_par[k]      : a_par_sel_s;
      b_par_sel_s = (winner_s == 3'(k)) ? cli_b_par[k]      : b_par_sel_s;
    end
  end

  // Completion vector, next pointer and wait-bound detection.
  always_comb begin
    done_vec_s = ONE << grant_id;
    if (grant_id == 3'(N_CLI - 1)) begin
      nxt_ptr_s = 3'd0;
    end else begin
      nxt_ptr_s = grant_id + 3'd1;
    end
    tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT - 1));
  end

  // Handshake decode; a real response always wins over an expiring bound.
  always_comb begin
    capture_s = 1'b0;
    expire_s  = 1'b0;
    to_wait_s = 1'b0;
    case (state_r)
      ISSUE: begin
        capture_s = m_ack & m_result_rdy;
        to_wait_s = m_ack & ~m_result_rdy;
        expire_s  = ~m_ack & tmo_hit_s;
      end
      WAIT_RDY: begin
        capture_s = m_result_rdy;
        expire_s  = ~m_result_rdy & tmo_hit_s;
      end
      default: begin
        capture_s = 1'b0;
        expire_s  = 1'b0;
        to_wait_s = 1'b0;
      end
    endcase
  end

  // Main FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      rr_ptr_r       <= 3'd0;
      tmo_cnt_r      <= '0;
      grant_id       <= 3'd0;
      busy           <= 1'b0;
      m_req          <= 1'b0;
      m_a            <= 16'd0;
      m_b            <= 16'd0;
      m_a_par        <= 1'b0;
      m_b_par        <= 1'b0;
      cli_done       <= '0;
      cli_result     <= 32'd0;
      cli_result_par <= 1'b0;
      cli_par_err    <= 1'b0;
      cli_timeout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r   <= ISSUE;
            grant_id  <= winner_s;
            m_a       <= a_sel_s;
            m_b       <= b_sel_s;
            m_a_par   <= a_par_sel_s;
            m_b_par   <= b_par_sel_s;
            m_req     <= 1'b1;
            busy      <= 1'b1;
            tmo_cnt_r <= '0;
          end else begin
            state_r   <= IDLE;
          end
        end
        ISSUE, WAIT_RDY: begin
          if (capture_s) begin
            state_r        <= DONE;
            m_req          <= 1'b0;
            cli_done       <= done_vec_s;
            cli_result     <= m_result;
            cli_result_par <= m_result_par;
            cli_par_err    <= m_par_err;
            cli_timeout    <= 1'b0;
          end else if (expire_s) begin
            state_r        <= DONE;
            m_req          <= 1'b0;
            cli_done       <= done_vec_s;
            cli_result     <= 32'd0;
            cli_result_par <= 1'b0;
            cli_par_err    <= 1'b0;
            cli_timeout    <= 1'b1;
          end else if (to_wait_s) begin
            state_r   <= WAIT_RDY;
            m_req     <= 1'b0;
            tmo_cnt_r <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        DONE: begin
          // Result fields are only meaningful during the pulse; clear them after.
          state_r        <= IDLE;
          busy           <= 1'b0;
          rr_ptr_r       <= nxt_ptr_s;
          cli_done       <= '0;
          cli_result     <= 32'd0;
          cli_result_par <= 1'b0;
          cli_par_err    <= 1'b0;
          cli_timeout    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          m_req    <= 1'b0;
          cli_done <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
//   Directed bench for mult_arbiter (N_CLI=4, TIMEOUT=16). A table of
//   single-client transactions with hand-computed products is driven
//   through a small multiplier responder; hand-written sequences cover
//   round-robin order, reset mid-transaction and post-reset grant order.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cli_req;
  logic [63:0] cli_a;
  logic [63:0] cli_b;
  logic [3:0]  cli_a_par;
  logic [3:0]  cli_b_par;
  logic [3:0]  cli_done;
  logic [31:0] cli_result;
  logic        cli_result_par;
  logic        cli_par_err;
  logic        cli_timeout;
  logic        m_req;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_a_par;
  logic        m_b_par;
  logic        m_ack;
  logic        m_result_rdy;
  logic [31:0] m_result;
  logic        m_result_par;
  logic        m_par_err;
  logic        busy;
  logic [2:0]  grant_id;

  int total = 0;
  int bad   = 0;

  mult_arbiter #(.N_CLI(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
    .cli_a_par(cli_a_par), .cli_b_par(cli_b_par),
    .cli_done(cli_done), .cli_result(cli_result),
    .cli_result_par(cli_result_par), .cli_par_err(cli_par_err),
    .cli_timeout(cli_timeout),
    .m_req(m_req), .m_a(m_a), .m_b(m_b),
    .m_a_par(m_a_par), .m_b_par(m_b_par),
    .m_ack(m_ack), .m_result_rdy(m_result_rdy), .m_result(m_result),
    .m_result_par(m_result_par), .m_par_err(m_par_err),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cli;
    logic [15:0] a;
    logic [15:0] b;
    int          ack_dly;   // -1: never ack
    int          rdy_dly;   // cycles after ack, -1: never
    bit          stray;     // rdy with garbage data before ack
    bit          perr;      // m_par_err driven by the responder
    logic [31:0] exp_res;
    bit          exp_perr;
    bit          exp_tmo;
    int          exp_mreq;  // cycles m_req is seen high
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int c, input logic [15:0] a, input logic [15:0] b);
    cli_a     = (cli_a & ~(64'hFFFF << (c * 16))) | ({48'd0, a} << (c * 16));
    cli_b     = (cli_b & ~(64'hFFFF << (c * 16))) | ({48'd0, b} << (c * 16));
    cli_a_par = (cli_a_par & ~(4'b0001 << c)) | ({3'd0, ^a} << c);
    cli_b_par = (cli_b_par & ~(4'b0001 << c)) | ({3'd0, ^b} << c);
  endtask

  task automatic default_ops();
    for (int c = 0; c < 4; c++) set_ops(c, 16'(c + 1), 16'd7);
  endtask

  // Waits for a grant, answers with ack+rdy together, checks the pulse.
  task automatic serve_one(output int id);
    bit seen;
    logic signed [31:0] prod;
    seen = 1'b0;
    id   = -1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = m_req;
    end
    chk("serve_mreq_seen", 32'(seen), 32'd1);
    if (seen) begin
      id   = int'(grant_id);
      prod = $signed(m_a) * $signed(m_b);
      m_ack = 1'b1; m_result_rdy = 1'b1; m_result = prod;
      m_result_par = ^prod; m_par_err = 1'b0;
      @(negedge clk);
      m_ack = 1'b0; m_result_rdy = 1'b0;
      chk("serve_done", 32'(cli_done), 32'(4'b0001 << id));
      chk("serve_result", cli_result, 32'((id + 1) * 7));
      chk("serve_mreq_low", 32'(m_req), 32'd0);
      cli_req = cli_req & ~(4'b0001 << id);
      @(negedge clk);
      chk("serve_pulse_once", 32'(cli_done), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    int mcnt;
    bit seen;
    bit got;
    logic signed [31:0] prod;
    @(negedge clk);
    set_ops(v.cli, v.a, v.b);
    cli_req = 4'b0001 << v.cli;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = m_req;
    end
    chk("vec_mreq_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("vec_grant", 32'(grant_id), 32'(v.cli));
      chk("vec_m_ops", {m_a, m_b}, {v.a, v.b});
      chk("vec_m_par", 32'({m_a_par, m_b_par}), 32'({^v.a, ^v.b}));
      chk("vec_busy", 32'(busy), 32'd1);
      t = 0; mcnt = 1; got = 1'b0;
      while (t < 60 && !got) begin
        prod = $signed(m_a) * $signed(m_b);
        m_ack = (v.ack_dly >= 0) && (t == v.ack_dly);
        m_result_rdy = ((v.ack_dly >= 0) && (v.rdy_dly >= 0) && (t == v.ack_dly + v.rdy_dly))
                       || (v.stray && (t == 0));
        m_result = (v.stray && (t == 0)) ? 32'hDEAD_BEEF : prod;
        m_result_par = ^m_result;
        m_par_err = v.perr;
        @(negedge clk);
        t++;
        if (m_req) mcnt++;
        if (cli_done != 4'd0) got = 1'b1;
      end
      m_ack = 1'b0; m_result_rdy = 1'b0; m_par_err = 1'b0;
      chk("vec_done_seen", 32'(got), 32'd1);
      chk("vec_done_vec", 32'(cli_done), 32'(4'b0001 << v.cli));
      chk("vec_result", cli_result, v.exp_res);
      chk("vec_result_par", 32'(cli_result_par), 32'(^v.exp_res));
      chk("vec_par_err", 32'(cli_par_err), 32'(v.exp_perr));
      chk("vec_timeout", 32'(cli_timeout), 32'(v.exp_tmo));
      chk("vec_mreq_cycles", 32'(mcnt), 32'(v.exp_mreq));
      cli_req = 4'd0;
      @(negedge clk);
      chk("vec_pulse_once", 32'(cli_done), 32'd0);
      chk("vec_idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int id;
    bit seen;
    //              cli a         b        ack rdy st pe  exp_res        epe tmo mreq
    vecs[0] = '{1, 16'h0003, 16'hFFFB,  2,  1, 1'b0, 1'b0, 32'hFFFF_FFF1, 1'b0, 1'b0,  3};
    vecs[1] = '{2, 16'h7FFF, 16'h7FFF,  0,  0, 1'b0, 1'b1, 32'h3FFF_0001, 1'b1, 1'b0,  1};
    vecs[2] = '{0, 16'hFFFF, 16'h8000,  1,  2, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b0,  2};
    vecs[3] = '{3, 16'h1234, 16'h0010,  3,  0, 1'b1, 1'b0, 32'h0001_2340, 1'b0, 1'b0,  4};
    vecs[4] = '{2, 16'h0005, 16'h0006, -1,  0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 16};
    vecs[5] = '{1, 16'h0009, 16'h0009,  0, -1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1,  1};
    vecs[6] = '{0, 16'hFED4, 16'h00C8,  4,  3, 1'b0, 1'b0, 32'hFFFF_15A0, 1'b0, 1'b0,  5};
    vecs[7] = '{3, 16'h8000, 16'h8000,  0,  5, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0,  1};

    rst_n = 1'b1;
    cli_req = 4'd0; cli_a = 64'd0; cli_b = 64'd0; cli_a_par = 4'd0; cli_b_par = 4'd0;
    m_ack = 1'b0; m_result_rdy = 1'b0; m_result = 32'd0; m_result_par = 1'b0; m_par_err = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ctl", 32'({m_req, busy, grant_id, cli_done, cli_timeout, cli_par_err}), 32'd0);
    chk("reset_result", cli_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    default_ops();
    @(negedge clk);
    chk("idle_no_req", 32'({m_req, busy}), 32'd0);

    // All four request at once from reset: strict 0,1,2,3 order.
    cli_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve_one(id);
      chk("rr_order_all", 32'(id), 32'(i));
    end
    // Pointer wrapped back to 0, so 0 goes before 2.
    cli_req = 4'b0101;
    serve_one(id);
    chk("rr_order_0_first", 32'(id), 32'd0);
    serve_one(id);
    chk("rr_order_2_next", 32'(id), 32'd2);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while waiting for the result.
    @(negedge clk);
    default_ops();
    cli_req = 4'b0100;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = m_req;
    end
    chk("rst_seq_mreq_seen", 32'(seen), 32'd1);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("rst_seq_in_wait", 32'({m_req, busy, grant_id}), 32'({1'b0, 1'b1, 3'd2}));
    @(negedge clk);
    #2 rst_n = 1'b0;
    cli_req = 4'b1001;
    #1;
    chk("rst_async_ctl", 32'({m_req, busy, grant_id, cli_done, cli_result_par, cli_par_err,
                              cli_timeout, m_a_par, m_b_par}), 32'd0);
    chk("rst_async_ops", {m_a, m_b}, 32'd0);
    chk("rst_async_result", cli_result, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(cli_done), 32'd0);
    end
    rst_n = 1'b1;
    serve_one(id);
    chk("post_rst_first", 32'(id), 32'd0);
    serve_one(id);
    chk("post_rst_second", 32'(id), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
